printer_sink: RTL

Peripheral-side Centronics-style printer receiver for the Amstrad Plus/GX4000 I/O subsystem. It responds to the printer port that the CPU-side I/O block drives: it samples `printer_data` on the strobe, generates `printer_busy`/`printer_ack` handshakes, and buffers received bytes in a FIFO. The HPS/OSD side drains the FIFO to capture printer output to a file.

---
 rtl/printer_sink.sv | 127 ++++++++++++
 1 files changed

// File: rtl/printer_sink.sv
// Centronics-style printer receiver: strobe/busy/ack handshake into a FWFT byte FIFO
// that the HPS side drains.
//
// state    | meaning
// IDLE     | waiting for a rising strobe
// PUSH     | byte latched, waiting for FIFO room
// ACK      | ack pulse running (ACK_CYCLES cycles)
// WAIT_LOW | waiting for the host to release the strobe
module printer_sink #(
  parameter int DEPTH      = 16,
  parameter int ACK_CYCLES = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [7:0]               printer_data,
  input  logic                     printer_strobe,
  output logic                     printer_busy,
  output logic                     printer_ack,
  input  logic                     host_rd,
  output logic [7:0]               host_dout,
  output logic                     host_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     proto_err,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = $clog2(ACK_CYCLES + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PUSH     = 2'd1;
  localparam logic [1:0] ACK      = 2'd2;
  localparam logic [1:0] WAIT_LOW = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] ack_cnt_q, ack_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          strobe_q;
  logic          err_q, err_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];

  logic strobe_edge, fifo_full, fifo_empty, push, pop;

  assign strobe_edge = printer_strobe & ~strobe_q;
  assign fifo_full   = (count_q == CW'(DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign pop         = host_rd & ~fifo_empty;
  // When full, host_rd implies a pop, so the write slot frees up this same cycle.
  assign push        = enable & (state_q == PUSH) & (~fifo_full | host_rd);

  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    data_d    = data_q;
    if (!enable) begin
      state_d   = IDLE;
      ack_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (strobe_edge) begin
          data_d  = printer_data;
          state_d = PUSH;
        end
        PUSH: if (push) begin
          state_d   = ACK;
          ack_cnt_d = KW'(ACK_CYCLES - 1);
        end
        ACK: begin
          if (ack_cnt_q == '0) state_d = WAIT_LOW;
          else                 ack_cnt_d = ack_cnt_q - 1'b1;
        end
        WAIT_LOW: if (!printer_strobe) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  assign err_d = (strobe_edge & enable & (state_q != IDLE)) | (err_q & ~err_clr);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      ack_cnt_q <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_cnt_q <= ack_cnt_d;
      data_q   <= data_d;
      strobe_q <= printer_strobe;
      err_q    <= err_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push && !reset) mem_q[wr_ptr_q] <= data_q;
  end

  assign printer_busy = ~enable | (state_q != IDLE);
  assign printer_ack  = (state_q == ACK);
  assign host_valid   = ~fifo_empty;
  assign host_dout    = host_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count   = count_q;
  assign proto_err    = err_q;

endmodule
